// File: rtl/sobel_row_window_pkg.sv
// Shared definitions for the Sobel row-window block.
//
// Holds the codebase-wide width and state-encoding macros, each guarded so that
// an earlier definition takes precedence. It also holds the typed state enum and
// fill-count constants that sobel_row_window uses.
//
// Optional feature macro used by this block: SOBEL_ROW_STALL_CNT_EN.

`ifndef NUM_SOBEL_ACCELERATORS
`define NUM_SOBEL_ACCELERATORS 4
`endif

`ifndef SOBEL_IDATA_WIDTH
`define SOBEL_IDATA_WIDTH ((`NUM_SOBEL_ACCELERATORS + 2) * 8)
`endif

`ifndef SOBEL_ROW_CNT_WIDTH
`define SOBEL_ROW_CNT_WIDTH 12
`endif

`ifndef SROW_FILL
`define SROW_FILL  2'd0
`endif
`ifndef SROW_VALID
`define SROW_VALID 2'd1
`endif
`ifndef SROW_WAIT
`define SROW_WAIT  2'd2
`endif
`ifndef SROW_DONE
`define SROW_DONE  2'd3
`endif

package sobel_row_window_pkg;

    typedef enum logic [1:0] {
        StFill  = `SROW_FILL,
        StValid = `SROW_VALID,
        StWait  = `SROW_WAIT,
        StDone  = `SROW_DONE
    } srow_state_e;

    // Number of rows held since the last strip_start, saturating at a full window.
    localparam logic [1:0] FillOne  = 2'd1;
    localparam logic [1:0] FillFull = 2'd3;

endpackage

// File: rtl/sobel_stall_counter.sv
// Saturating 32-bit event counter.
//
// Ports:
//   clk    in   clock
//   reset  in   synchronous active-high reset, clears the count
//   inc    in   count one event this cycle
//   count  out  number of events seen since reset, holding at all-ones

module sobel_stall_counter (
    input  logic        clk,
    input  logic        reset,
    input  logic        inc,
    output logic [31:0] count
);

    logic [31:0] count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (inc && (count_q != 32'hFFFF_FFFF)) begin
            count_q <= count_q + 32'd1;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/sobel_row_window.sv
// Sliding 3-row window for one column strip of the Sobel pipeline.
//
// It accepts one image-row chunk per handshake from the row-read path. It keeps
// the three most recent rows of the current strip and presents them to the
// accelerator core as top (row1), middle (row2) and bottom (row3). The last
// window of a strip is flagged.
//
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   srd2srow_valid/_data     incoming row chunk
//   srd2srow_strip_start     chunk is row 0 of a new strip
//   srow2srd_ready           chunk accepted this cycle when valid is also high
//   cfg_image_height         rows per strip, latched on an accepted strip_start
//   srow2sacc_row1/2/3_data  window rows, top to bottom
//   srow2sacc_valid/_last    window present / window's bottom row is row height-1
//   sacc2srow_ready          downstream consumes the window
//   srow_overrun             sticky: a chunk arrived after the strip ended
//   srow_stall_cycles        window-stall counter, only with SOBEL_ROW_STALL_CNT_EN

module sobel_row_window
    import sobel_row_window_pkg::*;
#(
    parameter int unsigned ROW_CNT_WIDTH = `SOBEL_ROW_CNT_WIDTH,
    parameter int unsigned IDATA_WIDTH   = `SOBEL_IDATA_WIDTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     srd2srow_valid,
    input  logic [IDATA_WIDTH-1:0]   srd2srow_data,
    input  logic                     srd2srow_strip_start,
    output logic                     srow2srd_ready,
    input  logic [ROW_CNT_WIDTH-1:0] cfg_image_height,
    output logic [IDATA_WIDTH-1:0]   srow2sacc_row1_data,
    output logic [IDATA_WIDTH-1:0]   srow2sacc_row2_data,
    output logic [IDATA_WIDTH-1:0]   srow2sacc_row3_data,
    output logic                     srow2sacc_valid,
    output logic                     srow2sacc_last,
    input  logic                     sacc2srow_ready,
    output logic                     srow_overrun
`ifdef SOBEL_ROW_STALL_CNT_EN
    ,
    output logic [31:0]              srow_stall_cycles
`endif
);

    localparam logic [ROW_CNT_WIDTH-1:0] RowOne   = ROW_CNT_WIDTH'(1);
    localparam logic [ROW_CNT_WIDTH-1:0] RowThree = ROW_CNT_WIDTH'(3);
    localparam logic [ROW_CNT_WIDTH-1:0] RowMax   = '1;

    srow_state_e              state_q, state_d;
    logic [1:0]               fill_q, fill_d;
    logic [ROW_CNT_WIDTH-1:0] row_idx_q, row_idx_d;
    logic [ROW_CNT_WIDTH-1:0] height_q, height_d;
    logic [IDATA_WIDTH-1:0]   row1_q, row1_d;
    logic [IDATA_WIDTH-1:0]   row2_q, row2_d;
    logic [IDATA_WIDTH-1:0]   row3_q, row3_d;
    logic                     overrun_q, overrun_d;

    logic win_valid;
    logic win_last;
    logic in_ready;
    logic accept;
    logic consume;
    logic shift;

    // Output decode from the registered state.
    always_comb begin
        win_valid = (state_q == StValid);
        win_last  = win_valid && (row_idx_q == (height_q - RowOne));
        // While a window is up, a new row may only enter as the old window leaves.
        // On the last window nothing may enter, because the strip closes out.
        in_ready  = win_valid ? (sacc2srow_ready && !win_last) : 1'b1;
        accept    = srd2srow_valid && in_ready;
        consume   = win_valid && sacc2srow_ready;
    end

    // Next-state logic.
    always_comb begin
        state_d   = state_q;
        fill_d    = fill_q;
        row_idx_d = row_idx_q;
        height_d  = height_q;
        overrun_d = overrun_q;
        shift     = 1'b0;

        if (accept && srd2srow_strip_start) begin
            // A strip start wins in every state and abandons any partial strip.
            state_d   = StFill;
            fill_d    = FillOne;
            row_idx_d = '0;
            height_d  = (cfg_image_height < RowThree) ? RowThree : cfg_image_height;
        end else begin
            case (state_q)
                StFill: begin
                    if (accept) begin
                        shift  = 1'b1;
                        fill_d = fill_q + 2'd1;
                        if (fill_q == (FillFull - 2'd1)) begin
                            state_d = StValid;
                        end
                    end
                end
                StValid: begin
                    if (accept) begin
                        shift = 1'b1;
                    end else if (consume) begin
                        state_d = win_last ? StDone : StWait;
                    end
                end
                StWait: begin
                    if (accept) begin
                        shift   = 1'b1;
                        state_d = StValid;
                    end
                end
                StDone: begin
                    if (accept) begin
                        overrun_d = 1'b1;
                    end
                end
                default: state_d = StFill;
            endcase
        end

        if (shift && (row_idx_q != RowMax)) begin
            row_idx_d = row_idx_q + RowOne;
        end
    end

    // Row datapath.
    always_comb begin
        row1_d = row1_q;
        row2_d = row2_q;
        row3_d = row3_q;
        if (accept && srd2srow_strip_start) begin
            row1_d = '0;
            row2_d = '0;
            row3_d = srd2srow_data;
        end else if (shift) begin
            row1_d = row2_q;
            row2_d = row3_q;
            row3_d = srd2srow_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StFill;
            fill_q    <= '0;
            row_idx_q <= '0;
            height_q  <= RowThree;
            row1_q    <= '0;
            row2_q    <= '0;
            row3_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            fill_q    <= fill_d;
            row_idx_q <= row_idx_d;
            height_q  <= height_d;
            row1_q    <= row1_d;
            row2_q    <= row2_d;
            row3_q    <= row3_d;
            overrun_q <= overrun_d;
        end
    end

    assign srow2srd_ready      = in_ready;
    assign srow2sacc_valid     = win_valid;
    assign srow2sacc_last      = win_last;
    assign srow2sacc_row1_data = row1_q;
    assign srow2sacc_row2_data = row2_q;
    assign srow2sacc_row3_data = row3_q;
    assign srow_overrun        = overrun_q;

`ifdef SOBEL_ROW_STALL_CNT_EN
    sobel_stall_counter u_stall_counter (
        .clk   (clk),
        .reset (reset),
        .inc   (win_valid && !sacc2srow_ready),
        .count (srow_stall_cycles)
    );
`endif

endmodule
